// File: rtl/spi_block_pkg.sv
// spi_block_pkg: opcodes, block size and FSM state type shared by the key-card SPI framer
package spi_block_pkg;
  localparam logic [7:0] OP_AUTH_INIT = 8'h10;
  localparam logic [7:0] OP_AUTH      = 8'h11;
  localparam logic [7:0] OP_GET_ID    = 8'h12;
  localparam int         BLOCK_BYTES  = 16;
  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAITRDY, DRAIN, DONE} state_t;
endpackage

// File: rtl/spi_block_xfer.sv
// spi_block_xfer: frames opcode + 0..16 payload bytes + 0..16 response bytes onto an SPI master under one CS
// i_Clk, i_Rst_L         clock, async active-low reset
// i_Cmd_*, o_Cmd_Ready   command request (opcode, clamped lengths, payload block), accepted in IDLE
// o_Rsp_*                one-cycle completion pulse, timeout flag, response block held until next accept
// o_TX_*, i_TX_Ready     byte stream and per-CS byte count to the SPI master
// i_RX_DV, i_RX_Byte     received bytes from the SPI master
module spi_block_xfer #(
  parameter int BLOCK_BYTES      = spi_block_pkg::BLOCK_BYTES,
  parameter int MAX_BYTES_PER_CS = 33,
  parameter int TIMEOUT_CLKS     = 4096
) (
  input  logic                                  i_Clk,
  input  logic                                  i_Rst_L,
  input  logic                                  i_Cmd_Valid,
  output logic                                  o_Cmd_Ready,
  input  logic [7:0]                            i_Cmd_Opcode,
  input  logic [4:0]                            i_Cmd_Tx_Len,
  input  logic [4:0]                            i_Cmd_Rx_Len,
  input  logic [8*BLOCK_BYTES-1:0]              i_Cmd_Block,
  output logic                                  o_Rsp_Valid,
  output logic                                  o_Rsp_Err,
  output logic [8*BLOCK_BYTES-1:0]              o_Rsp_Block,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_TX_Count,
  output logic [7:0]                            o_TX_Byte,
  output logic                                  o_TX_DV,
  input  logic                                  i_TX_Ready,
  input  logic                                  i_RX_DV,
  input  logic [7:0]                            i_RX_Byte
);
  import spi_block_pkg::*;
  localparam int DW = 8*BLOCK_BYTES;
  localparam int CW = $clog2(MAX_BYTES_PER_CS+1);
  localparam int TW = $clog2(TIMEOUT_CLKS+1);
  localparam logic [4:0] LMAX = 5'(BLOCK_BYTES);
  state_t r_state;
  logic [7:0] r_op;
  logic [CW-1:0] r_tx, r_total, r_idx, r_rx_seen;
  logic [DW-1:0] r_sh;
  logic [TW-1:0] r_tmo;
  logic r_rdy_d;
  logic [4:0] w_tx, w_rx;
  logic [CW-1:0] w_total, w_rx_next, w_rsp_j;
  logic [7:0] w_byte;
  logic w_rx_cap, w_in_rsp, w_tmo_rst, w_tmo_hit;
  assign w_tx        = (i_Cmd_Tx_Len > LMAX) ? LMAX : i_Cmd_Tx_Len;
  assign w_rx        = (i_Cmd_Rx_Len > LMAX) ? LMAX : i_Cmd_Rx_Len;
  assign w_total     = CW'(1) + CW'(w_tx) + CW'(w_rx);
  assign o_Cmd_Ready = r_state == IDLE;
  assign w_rx_cap    = i_RX_DV && r_state != IDLE;
  assign w_rx_next   = r_rx_seen + CW'(w_rx_cap);
  // receive byte index r maps to response byte r-1-tx; opcode/payload echoes fall outside the window
  assign w_rsp_j     = r_rx_seen - CW'(1) - r_tx;
  assign w_in_rsp    = w_rx_cap && r_rx_seen > r_tx && r_rx_seen < r_total;
  // payload bytes come from the top of a shift register so the index never needs a variable slice
  assign w_byte      = (r_idx == '0) ? r_op : (r_idx <= r_tx) ? r_sh[DW-1 -: 8] : 8'h00;
  assign w_tmo_rst   = (i_TX_Ready && !r_rdy_d) || i_RX_DV;
  assign w_tmo_hit   = r_tmo == TW'(TIMEOUT_CLKS-1) && !w_tmo_rst;
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_tx        <= '0;
      r_total     <= '0;
      r_idx       <= '0;
      r_rx_seen   <= '0;
      r_sh        <= '0;
      r_tmo       <= '0;
      r_rdy_d     <= 1'b0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= '0;
      o_TX_Count  <= '0;
      o_Rsp_Valid <= 1'b0;
      o_Rsp_Err   <= 1'b0;
      o_Rsp_Block <= '0;
    end else begin
      o_TX_DV     <= 1'b0;
      o_Rsp_Valid <= 1'b0;
      r_rdy_d     <= i_TX_Ready;
      r_tmo       <= (r_state == IDLE || w_tmo_rst) ? '0 : r_tmo + 1'b1;
      r_rx_seen   <= w_rx_next;
      for (int k = 0; k < BLOCK_BYTES; k++)
        if (w_in_rsp && w_rsp_j == CW'(k)) o_Rsp_Block[DW-1-8*k -: 8] <= i_RX_Byte;
      case (r_state)
        IDLE: if (i_Cmd_Valid) begin
          r_op        <= i_Cmd_Opcode;
          r_tx        <= CW'(w_tx);
          r_total     <= w_total;
          o_TX_Count  <= w_total;
          r_sh        <= i_Cmd_Block;
          r_idx       <= '0;
          r_rx_seen   <= '0;
          o_Rsp_Block <= '0;
          o_Rsp_Err   <= 1'b0;
          r_state     <= ISSUE;
        end
        ISSUE: if (i_TX_Ready) begin
          o_TX_DV   <= 1'b1;
          o_TX_Byte <= w_byte;
          r_idx     <= r_idx + 1'b1;
          if (r_idx != '0 && r_idx <= r_tx) r_sh <= r_sh << 8;
          r_state   <= GUARD;
        end else if (w_tmo_hit) begin
          o_Rsp_Valid <= 1'b1;
          o_Rsp_Err   <= 1'b1;
          r_state     <= DONE;
        end
        // the master still shows ready in the cycle after a strobe, so it is ignored here
        GUARD: r_state <= WAITRDY;
        WAITRDY: if (r_idx == r_total) r_state <= DRAIN;
        else if (i_TX_Ready) r_state <= ISSUE;
        else if (w_tmo_hit) begin
          o_Rsp_Valid <= 1'b1;
          o_Rsp_Err   <= 1'b1;
          r_state     <= DONE;
        end
        // the final receive strobe may land in this very cycle, hence the look-ahead count
        DRAIN: if (w_rx_next == r_total) begin
          o_Rsp_Valid <= 1'b1;
          r_state     <= DONE;
        end else if (w_tmo_hit) begin
          o_Rsp_Valid <= 1'b1;
          o_Rsp_Err   <= 1'b1;
          r_state     <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
